// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that serialises one mode/address/data command per frame for the SPI
// slave RAM controller. Define MASTER_BURST_EN to build multi-byte mode 01 (auto-increment) reads.
module spi_master_ctrl #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [1:0] mode_i,
   input  logic [4:0] addr_i,
   input  logic [7:0] wdata_i,
   input  logic [3:0] burst_len_i,
   output logic       SCLK_o,
   output logic       CS_o,
   output logic       MOSI_o,
   input  logic       MISO_i,
   output logic       busy_o,
   output logic [7:0] rdata_o,
   output logic       rdata_valid_o,
   output logic       done_o,
   output logic       err_o
);

   localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, START, INF, DATA, STOP} state_t;

   state_t          state_q;
   logic [DivW-1:0] divCnt_q;
   logic [3:0]      bitCnt_q;
   logic            sclk_q;
   logic            cs_q;
   logic            mosi_q;
   logic            busy_q;
   logic            rdataValid_q;
   logic            done_q;
   logic            err_q;
   logic [7:0]      rdata_q;
   logic [7:0]      shift_q;
   logic [7:0]      wdata_q;
   logic [1:0]      mode_q;
   logic [4:0]      addr_q;

   logic       divWrap;
   logic       accept;
   logic       isWrite;
   logic       isRead;
   logic       isFinal;
   logic       mosi_d;
   logic [3:0] nextIdx;
   logic [7:0] infWord;
   logic [7:0] shift_d;

   assign divWrap = (divCnt_q == DivMax);
   assign accept  = (state_q == IDLE) && start_i && (mode_i != 2'b11);
   assign isWrite = (mode_q == 2'b10);
   assign isRead  = ~mode_q[1];
   assign infWord = {1'b0, addr_q, mode_q[1], mode_q[0]};
   assign shift_d = {MISO_i, shift_q[7:1]};
   assign nextIdx = bitCnt_q + 4'd1;

`ifdef MASTER_BURST_EN
   logic [3:0] byteCnt_q;
   logic [3:0] numBytes_q;
   logic       sclkFall;

   assign sclkFall = (state_q == DATA) && divWrap && sclk_q;
   assign isFinal  = (byteCnt_q == numBytes_q - 4'd1);

   // Burst length is fixed at accept; only mode 01 may ask for more than one byte.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byteCnt_q  <= '0;
         numBytes_q <= '0;
      end else if (accept) begin
         byteCnt_q  <= '0;
         numBytes_q <= (mode_i == 2'b01 && burst_len_i != 4'd0) ? burst_len_i : 4'd1;
      end else if (sclkFall && bitCnt_q == 4'd9 && !isFinal) begin
         byteCnt_q <= byteCnt_q + 4'd1;
      end
   end
`else
   logic unusedBurstLen;
   assign unusedBurstLen = ^burst_len_i;
   assign isFinal        = 1'b1;
`endif

   // MOSI value for the slot that begins at the coming falling edge.
   always_comb begin
      mosi_d = 1'b0;
      case (state_q)
         START:   mosi_d = infWord[0];
         INF:     mosi_d = (bitCnt_q == 4'd6) ? (isWrite & wdata_q[0]) : infWord[nextIdx[2:0]];
         DATA: begin
            if (bitCnt_q == 4'd9) begin
               mosi_d = ~isFinal & isWrite & wdata_q[0];
            end else if (!nextIdx[3]) begin
               mosi_d = isWrite & wdata_q[nextIdx[2:0]];
            end else begin
               mosi_d = 1'b0;
            end
         end
         default: mosi_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         divCnt_q     <= '0;
         bitCnt_q     <= '0;
         sclk_q       <= 1'b0;
         cs_q         <= 1'b1;
         mosi_q       <= 1'b0;
         busy_q       <= 1'b0;
         rdata_q      <= '0;
         rdataValid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         shift_q      <= '0;
         mode_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         rdataValid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         case (state_q)
            IDLE: begin
               divCnt_q <= '0;
               bitCnt_q <= '0;
               sclk_q   <= 1'b0;
               cs_q     <= 1'b1;
               mosi_q   <= 1'b0;
               if (start_i && mode_i == 2'b11) begin
                  err_q <= 1'b1;
               end else if (accept) begin
                  mode_q  <= mode_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  state_q <= START;
                  busy_q  <= 1'b1;
                  cs_q    <= 1'b0;
               end
            end
            // bitCnt_q counts the two half-periods of the idle SCLK period here.
            STOP: begin
               if (divWrap) begin
                  divCnt_q <= '0;
                  if (bitCnt_q[0]) begin
                     state_q  <= IDLE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     bitCnt_q <= '0;
                  end else begin
                     bitCnt_q <= nextIdx;
                  end
               end else begin
                  divCnt_q <= divCnt_q + 1'b1;
               end
            end
            default: begin
               if (!divWrap) begin
                  divCnt_q <= divCnt_q + 1'b1;
               end else begin
                  divCnt_q <= '0;
                  sclk_q   <= ~sclk_q;
                  if (!sclk_q) begin
                     if (state_q == DATA && isRead && bitCnt_q >= 4'd2) begin
                        shift_q <= shift_d;
                        if (bitCnt_q == 4'd9) begin
                           rdata_q      <= shift_d;
                           rdataValid_q <= 1'b1;
                        end
                     end
                  end else begin
                     mosi_q <= mosi_d;
                     if (state_q == START) begin
                        state_q  <= INF;
                        bitCnt_q <= '0;
                     end else if (state_q == INF) begin
                        if (bitCnt_q == 4'd6) begin
                           state_q  <= DATA;
                           bitCnt_q <= '0;
                        end else begin
                           bitCnt_q <= nextIdx;
                        end
                     end else if (bitCnt_q == 4'd9) begin
                        bitCnt_q <= '0;
                        if (isFinal) begin
                           state_q <= STOP;
                        end
                     end else begin
                        bitCnt_q <= nextIdx;
                        // Release CS ahead of d=9 so the slave sees CS high at that rising edge.
                        if (bitCnt_q == 4'd8 && isFinal) begin
                           cs_q <= 1'b1;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end

   assign SCLK_o        = sclk_q;
   assign CS_o          = cs_q;
   assign MOSI_o        = mosi_q;
   assign busy_o        = busy_q;
   assign rdata_o       = rdata_q;
   assign rdata_valid_o = rdataValid_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
SPI master that sits directly upstream of the SPI slave RAM controller and generates its SCLK, CS, MOSI and samples MISO. A host issues one command per frame: mode, 5-bit address and write data. The block serialises it into the slave's frame format: 2 mode bits, 5 address bits, then one or more 10-period data slots. It returns read bytes to the host with a valid pulse.

Parameters:
CLK_DIV, 2, SCLK half-period in clk cycles (>=1); SCLK frequency = f_clk/(2*CLK_DIV)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
start  input  1  command request; accepted only when busy=0
mode  input  2  00 read, 01 read with address auto-increment, 10 write, 11 illegal
addr  input  5  slave RAM address
wdata  input  8  write byte (mode 10)
burst_len  input  4  bytes to read in mode 01 (0 treated as 1); used only with MASTER_BURST_EN
SCLK  output  1  serial clock to slave, idle low
CS  output  1  chip select, active low, idle high
MOSI  output  1  serial data to slave
MISO  input  1  serial data from slave
busy  output  1  high from accept until done
rdata  output  8  last received byte
rdata_valid  output  1  one-clk pulse per received byte
done  output  1  one-clk pulse at end of frame
err  output  1  one-clk pulse when a start with mode 11 is rejected

Behaviour:
- Reset: SCLK=0, CS=1, MOSI=0, busy=0, rdata=0, rdata_valid=0, done=0, err=0, state IDLE, all counters 0. Reset mid-frame aborts immediately: CS high, SCLK low, no done pulse.
- Command capture: on posedge with start=1 and busy=0, mode/addr/wdata/burst_len are latched and busy rises next cycle. start while busy=1 is ignored. If mode=11: no frame, busy stays 0, err pulses next cycle.
- Half-period counter: counts 0..CLK_DIV-1 while not IDLE. At wrap it toggles SCLK. MOSI/CS change only on wrap into SCLK low (falling edge). MISO is sampled in the clk cycle where SCLK goes high (rising edge).
- FSM states, each measured in SCLK periods:
  IDLE: CS=1, SCLK=0.
  START: CS low; 1 period with MOSI=0, giving the slave its CS-detect edge.
  INF: 7 periods. MOSI = mode[0], mode[1], addr[0]..addr[4] (LSB first).
  DATA: 10 periods per byte, index d=0..9.
  - Write: MOSI = wdata[d] for d=0..7 (LSB first); MOSI=0 for d=8,9.
  - Read: MOSI=0. MISO is sampled on the rising edges of d=2..9 into a shift register, LSB first (bit d-2). After the rising edge of d=9: rdata updates and rdata_valid pulses.
  STOP: SCLK held low, CS high for 1 full SCLK period. Then done pulses, busy falls and the FSM returns to IDLE.
- CS release: CS goes high on the falling edge that begins d=9 of the final byte, so the slave sees CS=1 at that rising edge. For non-final burst bytes, CS stays low through d=9 and the byte counter advances.
- Frame length: (8+10*N) SCLK periods with CS low, plus STOP. N=1 except for mode 01 bursts.
- Next start is accepted on the cycle after done (busy=0).

Optional Feature:
MASTER_BURST_EN
- Defined: in mode 01, N = burst_len (0 -> 1). rdata_valid pulses N times; rdata holds each byte until the next pulse.
- Undefined: burst_len is ignored, N=1 for all modes, and the burst byte counter is not built.

Test Plan:
- CLK_DIV=2; write mode=10, addr=0x05, wdata=0xA5 -> MOSI on rising edges 2..18 = 0,1, 1,0,1,0,0, 1,0,1,0,0,1,0,1, 0,0; 18 SCLK rising edges with CS low; CS=1 at the 18th rising edge; done once; rdata_valid never.
- Read mode=00, addr=0x1F, slave model drives 0x3C on d=2..9 -> rdata=0x3C, one rdata_valid; done follows after the STOP period (2*CLK_DIV clk cycles).
- start with mode=11 -> err pulses once, CS stays 1, SCLK never toggles, busy stays 0.
- MASTER_BURST_EN defined: mode=01, addr=0x1E, burst_len=3, model returns 0x11,0x22,0x33 -> three rdata_valid pulses with those values; 38 SCLK periods with CS low; CS high only in the last d=9.
- start pulsed again during a write frame -> ignored, frame bits unchanged. rst asserted at INF bit 3 -> next cycle CS=1, SCLK=0, busy=0, no done.
- CLK_DIV=1 write frame -> SCLK toggles every clk cycle; bit pattern identical to the first scenario.
